wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback select for the 5-stage MIPS pipeline.
- It is the writer side of the register file's write port. It drives RegWrite, Write_register and Write_data, which the register file also forwards combinationally to its read ports in the same cycle.
- It also extracts load sub-words (lb/lbu/lh/lhu/lw) and counts retired instructions.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_valid  input  1  MEM stage holds a real instruction (0 = bubble).
- stall  input  1  hold the WB register contents this cycle.
- flush  input  1  squash: WB becomes a bubble at the next edge.
- RegWrite_in  input  1  instruction writes a GPR.
- Write_register_in  input  5  destination register number.
- MemtoReg  input  2  writeback source: 00 ALU, 01 load data, 10 PC+4 (link), 11 treated as ALU.
- LoadType  input  3  load kind: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; 101–111 treated as lw.
- Addr_lo  input  2  address bits [1:0] of the load.
- ALU_out  input  32  ALU result.
- Mem_data  input  32  raw word read from data memory.
- PC_plus4  input  32  link value.
- RegWrite  output  1  register file write enable.
- Write_register  output  5  register file write address.
- Write_data  output  32  register file write data.
- wb_valid  output  1  WB holds a real instruction.
- retired_count  output  COUNT_WIDTH  number of instructions that have entered WB.

Behaviour:
- Registers held: valid_q, RegWrite_q, Write_register_q, MemtoReg_q, LoadType_q, Addr_lo_q, ALU_q, Mem_q, PC4_q, cnt_q.
- Reset (asynchronous, takes effect immediately):
  - all registers go to 0;
  - RegWrite=0, Write_register=0, Write_data=0, wb_valid=0, retired_count=0.
  - Reset asserted mid-operation discards the in-flight instruction; no write occurs while reset is high.
- Update at each rising clk when reset=0, priority flush > stall > load:
  - flush=1: valid_q<=0. All other fields are don't-care, but must not produce a write.
  - flush=0, stall=1: every register holds.
  - Otherwise: all fields capture their inputs, and valid_q<=mem_valid.
- Latency: one cycle from the MEM-stage inputs to the register file write.
- Outputs are combinational from the registers only; there is no combinational path from the inputs to the outputs.
  - wb_valid = valid_q.
  - RegWrite = valid_q & RegWrite_q & (Write_register_q != 0).
  - Write_register = Write_register_q.
- During a stall the held instruction keeps RegWrite asserted. Rewriting the same value is harmless and keeps the register file bypass correct.
- Write_data mux:
  - MemtoReg_q = 10: PC4_q.
  - MemtoReg_q = 01: load_ext.
  - Otherwise: ALU_q.
  - When RegWrite=0, Write_data is still the mux output; it is not forced to zero.
- load_ext, little-endian (byte k = Mem_q[8k+7:8k]):
  - lb / lbu: byte Addr_lo_q, sign- or zero-extended to 32 bits.
  - lh / lhu: halfword Addr_lo_q[1] (0 → [15:0], 1 → [31:16]), sign- or zero-extended; Addr_lo_q[0] is ignored.
  - lw: Mem_q, with Addr_lo_q ignored.
- retired_count:
  - increments by 1 at any edge where mem_valid=1, stall=0 and flush=0;
  - wraps modulo 2^COUNT_WIDTH (all-ones + 1 → 0);
  - does not increment on bubbles, stalls, flushes or during reset.
- Simultaneous stall and flush: flush wins. The bubble is inserted and the counter does not increment.
- A destination of $0 is never written, even if RegWrite_in=1.

Test Plan:
- Reset, then mem_valid=1, RegWrite_in=1, Write_register_in=5, MemtoReg=00, ALU_out=0x1234 → next cycle RegWrite=1, Write_register=5, Write_data=0x1234, retired_count=1.
- Load extraction with Mem_data=0x80FF7F01, MemtoReg=01:
  - lb, Addr_lo=3 → 0xFFFFFF80.
  - lbu, Addr_lo=3 → 0x00000080.
  - lh, Addr_lo=2 → 0xFFFF80FF.
  - lhu, Addr_lo=0 → 0x00007F01.
  - lw, Addr_lo=2 → 0x80FF7F01.
- Link: MemtoReg=10, PC_plus4=0x00400008, Write_register_in=31 → Write_data=0x00400008, RegWrite=1. Repeat with Write_register_in=0 → RegWrite=0.
- Stall/flush:
  - Hold stall=1 for 3 cycles while the inputs change → the outputs stay frozen and retired_count is unchanged.
  - Assert stall=1 and flush=1 together → next cycle wb_valid=0 and RegWrite=0.
- Bubble: mem_valid=0 with RegWrite_in=1 → RegWrite=0 and the counter is unchanged.
- Counter wrap: with COUNT_WIDTH=4, issue 17 valid instructions → retired_count=1.
- Asynchronous reset mid-cycle while RegWrite=1 → RegWrite drops to 0 before the next clk edge.

Source files
------------

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback select: holds the retiring instruction,
// extracts load sub-words, drives the register file write port and counts retirements.
module wb_stage #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_valid,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   RegWrite_in,
  input  logic [4:0]             Write_register_in,
  input  logic [1:0]             MemtoReg,
  input  logic [2:0]             LoadType,
  input  logic [1:0]             Addr_lo,
  input  logic [31:0]            ALU_out,
  input  logic [31:0]            Mem_data,
  input  logic [31:0]            PC_plus4,
  output logic                   RegWrite,
  output logic [4:0]             Write_register,
  output logic [31:0]            Write_data,
  output logic                   wb_valid,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  logic                   valid_q, valid_d;
  logic                   RegWrite_q, RegWrite_d;
  logic [4:0]             Write_register_q, Write_register_d;
  logic [1:0]             MemtoReg_q, MemtoReg_d;
  logic [2:0]             LoadType_q, LoadType_d;
  logic [1:0]             Addr_lo_q, Addr_lo_d;
  logic [31:0]            ALU_q, ALU_d;
  logic [31:0]            Mem_q, Mem_d;
  logic [31:0]            PC4_q, PC4_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]            load_ext;

  // Little-endian sub-word pick; the halfword ignores Addr_lo[0].
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  kind,
                                               input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (kind)
      3'b001:  load_extract = {{24{b[7]}}, b};
      3'b010:  load_extract = {24'h0, b};
      3'b011:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {16'h0, h};
      default: load_extract = word;
    endcase
  endfunction

  always_comb begin
    valid_d          = valid_q;
    RegWrite_d       = RegWrite_q;
    Write_register_d = Write_register_q;
    MemtoReg_d       = MemtoReg_q;
    LoadType_d       = LoadType_q;
    Addr_lo_d        = Addr_lo_q;
    ALU_d            = ALU_q;
    Mem_d            = Mem_q;
    PC4_d            = PC4_q;
    cnt_d            = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d          = mem_valid;
      RegWrite_d       = RegWrite_in;
      Write_register_d = Write_register_in;
      MemtoReg_d       = MemtoReg;
      LoadType_d       = LoadType;
      Addr_lo_d        = Addr_lo;
      ALU_d            = ALU_out;
      Mem_d            = Mem_data;
      PC4_d            = PC_plus4;
      if (mem_valid) cnt_d = cnt_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q          <= 1'b0;
      RegWrite_q       <= 1'b0;
      Write_register_q <= 5'd0;
      MemtoReg_q       <= 2'd0;
      LoadType_q       <= 3'd0;
      Addr_lo_q        <= 2'd0;
      ALU_q            <= 32'h0;
      Mem_q            <= 32'h0;
      PC4_q            <= 32'h0;
      cnt_q            <= '0;
    end else begin
      valid_q          <= valid_d;
      RegWrite_q       <= RegWrite_d;
      Write_register_q <= Write_register_d;
      MemtoReg_q       <= MemtoReg_d;
      LoadType_q       <= LoadType_d;
      Addr_lo_q        <= Addr_lo_d;
      ALU_q            <= ALU_d;
      Mem_q            <= Mem_d;
      PC4_q            <= PC4_d;
      cnt_q            <= cnt_d;
    end
  end

  // Writeback stage: outputs depend on the registers only.
  always_comb begin
    load_ext       = load_extract(Mem_q, LoadType_q, Addr_lo_q);
    wb_valid       = valid_q;
    RegWrite       = valid_q & RegWrite_q & (Write_register_q != 5'd0);
    Write_register = Write_register_q;
    retired_count  = cnt_q;
    case (MemtoReg_q)
      2'b10:   Write_data = PC4_q;
      2'b01:   Write_data = load_ext;
      default: Write_data = ALU_q;
    endcase
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a 32-bit-counter instance plus a 4-bit-counter
// instance fed the same stimulus, checked against hand-computed values.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        RegWrite_in = 1'b0;
  logic [4:0]  Write_register_in = 5'd0;
  logic [1:0]  MemtoReg = 2'd0;
  logic [2:0]  LoadType = 3'd0;
  logic [1:0]  Addr_lo = 2'd0;
  logic [31:0] ALU_out = 32'h0, Mem_data = 32'h0, PC_plus4 = 32'h0;

  logic        RegWrite, wb_valid;
  logic [4:0]  Write_register;
  logic [31:0] Write_data, retired_count;

  logic        RegWrite4, wb_valid4;
  logic [4:0]  Write_register4;
  logic [31:0] Write_data4;
  logic [3:0]  retired_count4;

  int n_total = 0;
  int n_bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  wb_stage #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .stall(stall), .flush(flush),
    .RegWrite_in(RegWrite_in), .Write_register_in(Write_register_in),
    .MemtoReg(MemtoReg), .LoadType(LoadType), .Addr_lo(Addr_lo),
    .ALU_out(ALU_out), .Mem_data(Mem_data), .PC_plus4(PC_plus4),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
    .wb_valid(wb_valid), .retired_count(retired_count)
  );

  wb_stage #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .stall(stall), .flush(flush),
    .RegWrite_in(RegWrite_in), .Write_register_in(Write_register_in),
    .MemtoReg(MemtoReg), .LoadType(LoadType), .Addr_lo(Addr_lo),
    .ALU_out(ALU_out), .Mem_data(Mem_data), .PC_plus4(PC_plus4),
    .RegWrite(RegWrite4), .Write_register(Write_register4), .Write_data(Write_data4),
    .wb_valid(wb_valid4), .retired_count(retired_count4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] m2r, input logic [31:0] alu);
    mem_valid = 1'b1; RegWrite_in = 1'b1; Write_register_in = rd;
    MemtoReg = m2r; ALU_out = alu;
  endtask

  initial begin
    logic [2:0]  lt_tab [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
    logic [1:0]  lo_tab [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd2};
    logic [31:0] ld_exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                32'h00007F01, 32'h80FF7F01};

    step(); step();
    check("rst_regwrite", {31'b0, RegWrite}, 32'd0);
    check("rst_wreg", {27'b0, Write_register}, 32'd0);
    check("rst_wdata", Write_data, 32'd0);
    check("rst_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_count", retired_count, 32'd0);
    reset = 1'b0;

    issue(5'd5, 2'b00, 32'h1234);
    step(); exp_cnt++;
    check("alu_regwrite", {31'b0, RegWrite}, 32'd1);
    check("alu_wreg", {27'b0, Write_register}, 32'd5);
    check("alu_wdata", Write_data, 32'h1234);
    check("alu_count", retired_count, 32'd1);
    check("alu_valid", {31'b0, wb_valid}, 32'd1);

    Mem_data = 32'h80FF7F01; MemtoReg = 2'b01;
    for (int i = 0; i < 5; i++) begin
      LoadType = lt_tab[i]; Addr_lo = lo_tab[i];
      step(); exp_cnt++;
      check($sformatf("load%0d_wdata", i), Write_data, ld_exp[i]);
    end
    check("load_count", retired_count, exp_cnt);

    issue(5'd31, 2'b10, 32'hDEAD0000); PC_plus4 = 32'h00400008;
    step(); exp_cnt++;
    check("link_wdata", Write_data, 32'h00400008);
    check("link_regwrite", {31'b0, RegWrite}, 32'd1);
    Write_register_in = 5'd0;
    step(); exp_cnt++;
    check("r0_regwrite", {31'b0, RegWrite}, 32'd0);
    check("r0_wdata", Write_data, 32'h00400008);

    issue(5'd12, 2'b11, 32'h0BADF00D);
    step(); exp_cnt++;
    check("m2r11_wdata", Write_data, 32'h0BADF00D);

    issue(5'd7, 2'b00, 32'hAAAA);
    step(); exp_cnt++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Write_register_in = 5'd9 + 5'(i); ALU_out = 32'h5555 + i; MemtoReg = 2'b10;
      step();
      check("stall_wdata", Write_data, 32'hAAAA);
      check("stall_wreg", {27'b0, Write_register}, 32'd7);
      check("stall_regwrite", {31'b0, RegWrite}, 32'd1);
      check("stall_count", retired_count, exp_cnt);
    end

    flush = 1'b1;
    step();
    check("sf_valid", {31'b0, wb_valid}, 32'd0);
    check("sf_regwrite", {31'b0, RegWrite}, 32'd0);
    check("sf_count", retired_count, exp_cnt);
    stall = 1'b0; flush = 1'b0;

    mem_valid = 1'b0; RegWrite_in = 1'b1; Write_register_in = 5'd3;
    step();
    check("bub_regwrite", {31'b0, RegWrite}, 32'd0);
    check("bub_count", retired_count, exp_cnt);

    issue(5'd8, 2'b00, 32'h77);
    step(); exp_cnt++;
    check("pre_arst_regwrite", {31'b0, RegWrite}, 32'd1);
    check("pre_arst_count", retired_count, exp_cnt);
    mem_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_regwrite", {31'b0, RegWrite}, 32'd0);
    check("arst_wdata", Write_data, 32'd0);
    check("arst_count", retired_count, 32'd0);
    check("arst_count4", {28'b0, retired_count4}, 32'd0);
    step();
    reset = 1'b0; exp_cnt = 0;

    issue(5'd4, 2'b00, 32'h1);
    for (int i = 0; i < 17; i++) step();
    mem_valid = 1'b0;
    check("wrap_count4", {28'b0, retired_count4}, 32'd1);
    check("wrap_count32", retired_count, 32'd17);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
